// File: rtl/sirv_spi_xfer_ctrl_if.sv
// sirv_spi_xfer_ctrl_if
//   Byte transfer handshake between a byte producer/consumer and the SPI
//   frame sequencer.
//   tx_valid/tx_ready : byte request, taken when both are high
//   tx_data           : byte to send, MSB first
//   tx_dir            : dual/quad only, 1 = drive lanes, 0 = receive
//   rx_valid          : one-cycle pulse, rx_data valid (no backpressure)
//   rx_data           : received byte
//   master modport: the byte producer side; slave modport: the sequencer.
interface sirv_spi_xfer_ctrl_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_dir;
    logic       rx_valid;
    logic [7:0] rx_data;

    modport master (
        output tx_valid, tx_data, tx_dir,
        input  tx_ready, rx_valid, rx_data
    );

    modport slave (
        input  tx_valid, tx_data, tx_dir,
        output tx_ready, rx_valid, rx_data
    );
endinterface

// File: rtl/sirv_spi_xfer_ctrl.sv
// sirv_spi_xfer_ctrl
//   Byte-frame SPI master sequencer. Takes bytes over a valid/ready
//   handshake, generates SCK from a programmable half-period divider,
//   shifts data out on 1/2/4 lanes and assembles the received byte.
//   Handles CS setup, hold-between-frames and release.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   cfg_*        : live configuration, latched when a byte is accepted
//   bus          : tx/rx byte handshake (slave modport)
//   spi_sck      : SCK pin
//   spi_dq_o/oe  : lane output values / enables
//   spi_dq_i     : lane input values
//   spi_cs       : chip selects, active low
//   busy         : sequencer not idle
module sirv_spi_xfer_ctrl #(
    parameter int DIV_WIDTH = 12,
    parameter int CS_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic                 cfg_cpol,
    input  logic                 cfg_cpha,
    input  logic [1:0]           cfg_proto,
    input  logic [1:0]           cfg_csid,
    input  logic                 cfg_cshold,
    sirv_spi_xfer_ctrl_if.slave  bus,
    output logic                 spi_sck,
    output logic [3:0]           spi_dq_o,
    output logic [3:0]           spi_dq_oe,
    input  logic [3:0]           spi_dq_i,
    output logic [CS_WIDTH-1:0]  spi_cs,
    output logic                 busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_XFER  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_CSEND = 3'd4;

    logic [2:0]           state;
    logic                 live;      // low only in the first cycle after reset
    logic [DIV_WIDTH-1:0] div_q;
    logic                 cpol_q;
    logic                 cpha_q;
    logic [1:0]           proto_q;
    logic [1:0]           csid_q;
    logic                 cshold_q;
    logic                 dir_q;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [3:0]           hp;        // half-period index within XFER
    logic [7:0]           tx_sh;
    logic [7:0]           rx_sh;
    logic                 rx_valid_q;
    logic [7:0]           rx_data_q;

    logic       tick;
    logic [3:0] hp_next;
    logic [3:0] last_hp;
    logic       at_last;
    logic       xfer_tick;
    logic       lead_ev;
    logic       trail_ev;
    logic       sample_ev;
    logic       shift_ev;
    logic       same_cs;
    logic       accept_idle;
    logic       accept_hold;
    logic       accept;
    logic [7:0] rx_next;
    logic [7:0] tx_shifted;
    logic [3:0] tx_lanes;
    logic [3:0] oe_mask;
    logic       drive;
    logic       cs_active;

    assign tick      = (div_cnt == '0);
    assign hp_next   = hp + 4'd1;
    assign at_last   = (hp == last_hp);
    assign xfer_tick = (state == ST_XFER) && tick;

    // XFER half-period k has SCK = cpol ^ k[0], so entering an odd k is a
    // leading edge and entering an even k (>=2) is a trailing edge. The last
    // trailing edge coincides with leaving XFER.
    assign lead_ev  = xfer_tick && !at_last &&  hp_next[0];
    assign trail_ev = xfer_tick && !at_last && !hp_next[0];
    // cpha=1: the first leading edge does not shift, bit 7 is already out.
    assign sample_ev = cpha_q ? trail_ev : lead_ev;
    assign shift_ev  = cpha_q ? (lead_ev && (hp_next != 4'd1)) : trail_ev;

    assign same_cs     = (cfg_csid == csid_q);
    assign accept_idle = (state == ST_IDLE) && live && bus.tx_valid;
    assign accept_hold = (state == ST_HOLD) && bus.tx_valid && same_cs;
    assign accept      = accept_idle || accept_hold;

    always_comb begin
        last_hp    = 4'd15;
        rx_next    = {rx_sh[6:0], spi_dq_i[1]};
        tx_shifted = {tx_sh[6:0], 1'b0};
        tx_lanes   = {3'b000, tx_sh[7]};
        oe_mask    = 4'b0001;
        case (proto_q)
            2'd0: ;
            2'd1: begin
                last_hp    = 4'd7;
                rx_next    = {rx_sh[5:0], spi_dq_i[1:0]};
                tx_shifted = {tx_sh[5:0], 2'b00};
                tx_lanes   = {2'b00, tx_sh[7:6]};
                oe_mask    = dir_q ? 4'b0011 : 4'b0000;
            end
            default: begin
                last_hp    = 4'd3;
                rx_next    = {rx_sh[3:0], spi_dq_i};
                tx_shifted = {tx_sh[3:0], 4'b0000};
                tx_lanes   = tx_sh[7:4];
                oe_mask    = dir_q ? 4'b1111 : 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            live       <= 1'b0;
            div_q      <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            proto_q    <= '0;
            csid_q     <= '0;
            cshold_q   <= 1'b0;
            dir_q      <= 1'b0;
            div_cnt    <= '0;
            hp         <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            live       <= 1'b1;
            rx_valid_q <= 1'b0;

            if (state == ST_SETUP || state == ST_XFER || state == ST_CSEND)
                div_cnt <= tick ? div_q : div_cnt - DIV_WIDTH'(1);
            if (shift_ev)
                tx_sh <= tx_shifted;
            if (sample_ev)
                rx_sh <= rx_next;

            if (accept) begin
                div_q    <= cfg_div;
                cpol_q   <= cfg_cpol;
                cpha_q   <= cfg_cpha;
                proto_q  <= cfg_proto;
                csid_q   <= cfg_csid;
                cshold_q <= cfg_cshold;
                dir_q    <= bus.tx_dir;
                tx_sh    <= bus.tx_data;
                rx_sh    <= '0;
                hp       <= '0;
                div_cnt  <= cfg_div;
            end

            case (state)
                ST_IDLE:  if (accept_idle) state <= ST_SETUP;
                ST_SETUP: if (tick) state <= ST_XFER;
                ST_XFER: begin
                    if (tick) begin
                        if (at_last) begin
                            rx_valid_q <= 1'b1;
                            // cpha=1 takes its final sample on the exit edge
                            rx_data_q  <= cpha_q ? rx_next : rx_sh;
                            state      <= cshold_q ? ST_HOLD : ST_CSEND;
                        end else begin
                            hp <= hp_next;
                        end
                    end
                end
                ST_HOLD: begin
                    if (accept_hold) begin
                        state <= ST_XFER;
                    end else if (!cfg_cshold || bus.tx_valid) begin
                        // a request for another CS stays pending until IDLE
                        state   <= ST_CSEND;
                        div_cnt <= div_q;
                    end
                end
                ST_CSEND: if (tick) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign drive     = (state == ST_SETUP) || (state == ST_XFER);
    assign cs_active = (state != ST_IDLE);

    always_comb begin
        case (state)
            ST_IDLE: spi_sck = live ? cfg_cpol : 1'b0;
            ST_XFER: spi_sck = cpol_q ^ hp[0];
            default: spi_sck = cpol_q;
        endcase
    end

    assign spi_dq_oe = drive ? oe_mask : 4'b0000;
    assign spi_dq_o  = tx_lanes & spi_dq_oe;

    always_comb begin
        spi_cs = '1;
        for (int unsigned i = 0; i < CS_WIDTH; i++)
            if (cs_active && (i == 32'(csid_q)))
                spi_cs[i] = 1'b0;
    end

    // In HOLD a request for a different CS is refused so it survives the
    // trip through CSEND and IDLE.
    always_comb begin
        case (state)
            ST_IDLE: bus.tx_ready = live;
            ST_HOLD: bus.tx_ready = !(bus.tx_valid && !same_cs);
            default: bus.tx_ready = 1'b0;
        endcase
    end

    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
    assign busy         = (state != ST_IDLE);

endmodule
